// File: rtl/lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_bus_sequencer: turns LCD register updates into timed HD44780 write cycles
// Rev 1.0
// ============================================================================
module lcd_bus_sequencer #(
    parameter int T_SETUP     = 4,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_busy,
    output logic        o_lcd_overrun
);

    localparam int T_MAX_A = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
    localparam int CW      = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] EXEC_LAST  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [10:0]     prev_q;
    logic            slot_vld_q, slot_vld_d;
    logic            slot_rs_q, slot_rs_d;
    logic [7:0]      slot_data_q, slot_data_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic            on_q;
    logic            req;
    logic            consume;
    logic            exec_long;
    logic [CW-1:0]   exec_last;
    logic            unused_bits;

    assign unused_bits = ^{i_io_lcd[30:11]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        rs_d        = rs_q;
        data_d      = data_q;
        consume     = 1'b0;
        // Clear display / return home need the long execution wait.
        exec_long   = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
        exec_last   = exec_long ? LONG_LAST : EXEC_LAST;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (slot_vld_q) begin
                    consume = 1'b1;
                    rs_d    = slot_rs_q;
                    data_d  = slot_data_q;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: if (cnt_q == SETUP_LAST) begin state_d = S_PULSE; cnt_d = '0; end
            S_PULSE: if (cnt_q == PULSE_LAST) begin state_d = S_HOLD;  cnt_d = '0; end
            S_HOLD:  if (cnt_q == HOLD_LAST)  begin state_d = S_EXEC;  cnt_d = '0; end
            S_EXEC:  if (cnt_q == exec_last)  begin state_d = S_IDLE;  cnt_d = '0; end
            default: begin state_d = S_IDLE; cnt_d = '0; end
        endcase

        req         = (i_io_lcd[10:0] != prev_q);
        slot_vld_d  = slot_vld_q & ~consume;
        slot_rs_d   = slot_rs_q;
        slot_data_d = slot_data_q;
        ovr_d       = ovr_q;
        if (req) begin
            slot_vld_d  = 1'b1;
            slot_rs_d   = i_io_lcd[10];
            slot_data_d = i_io_lcd[7:0];
            if (slot_vld_q && !consume) ovr_d = 1'b1;
        end

        en_d   = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE) | slot_vld_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prev_q      <= '0;
            slot_vld_q  <= 1'b0;
            slot_rs_q   <= 1'b0;
            slot_data_q <= '0;
            rs_q        <= 1'b0;
            data_q      <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= i_io_lcd[10:0];
            slot_vld_q  <= slot_vld_d;
            slot_rs_q   <= slot_rs_d;
            slot_data_q <= slot_data_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            on_q        <= i_io_lcd[31];
        end
    end

    assign o_lcd_on      = on_q;
    assign o_lcd_rs      = rs_q;
    assign o_lcd_rw      = 1'b0;
    assign o_lcd_en      = en_q;
    assign o_lcd_data    = data_q;
    assign o_lcd_busy    = busy_q;
    assign o_lcd_overrun = ovr_q;

endmodule
`default_nettype wire
